// File: rtl/controler_enigma.sv
// -----------------------------------------------------------------------------
// controler_enigma
//   Glue controller between a UART and an Enigma encryption core.
//   Received letters are sent to the core one at a time. Results are converted
//   back to ASCII, queued in a small FIFO and handed to the UART transmitter.
//   A '#' followed by three letters loads new rotor start positions.
//   A '!' clears the FIFO and the error flag from any state.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   rx_byte        received UART byte, qualified by rx_done
//   rx_done        one-cycle strobe for rx_byte
//   core_valid_in  one-cycle request strobe to the core
//   core_char_in   letter index 0..25 sent to the core
//   core_char_out  encrypted index from the core, qualified by core_valid_out
//   core_valid_out one-cycle result strobe from the core
//   cfg_load       one-cycle strobe, core latches cfg_pos
//   cfg_pos        rotor positions {left, mid, right}
//   tx_start       one-cycle strobe to start a UART transmission
//   tx_din         byte to transmit, held for the whole transfer
//   tx_active      UART transmitter busy
//   err            sticky error (core timeout or FIFO overflow)
//   busy           command FSM not idle or FIFO not empty
// -----------------------------------------------------------------------------
module controler_enigma #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_done,
  output logic        core_valid_in,
  output logic [4:0]  core_char_in,
  input  logic [4:0]  core_char_out,
  input  logic        core_valid_out,
  output logic        cfg_load,
  output logic [14:0] cfg_pos,
  output logic        tx_start,
  output logic [7:0]  tx_din,
  input  logic        tx_active,
  output logic        err,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG1      = 3'd1,
    CFG2      = 3'd2,
    CFG3      = 3'd3,
    WAIT_CORE = 3'd4
  } cmd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_t;

  // Command side state
  cmd_state_t       cmd_q, cmd_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [4:0]       left_q, left_d;
  logic [4:0]       mid_q, mid_d;
  logic [14:0]      cfg_pos_q, cfg_pos_d;
  logic             load_pend_q, load_pend_d;
  logic             cfg_load_q, cfg_load_d;
  logic             core_valid_in_q, core_valid_in_d;
  logic [4:0]       core_char_in_q, core_char_in_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // FIFO state
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // TX side state
  tx_state_t        tx_q, tx_d;
  logic [7:0]       tx_din_q, tx_din_d;
  logic             tx_start_q, tx_start_d;
  logic             seen_q, seen_d;

  // Decode and handshake signals
  logic             is_letter_s;
  logic [4:0]       idx_s;
  logic             is_cmd_s;
  logic             is_clr_s;
  logic             flush_s;
  logic             push_s;
  logic             err_set_s;
  logic [7:0]       push_data_s;
  logic             pop_s;
  logic             do_push_s;
  logic             ovf_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  assign fifo_full_s  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty_s = (count_q == {CW{1'b0}});
  assign push_data_s  = {3'b000, core_char_out} + 8'd65;

  // Classify the received byte into letter / command / clear.
  always_comb begin
    // 'A' and 'a' both have low five bits 00001, so one subtraction covers both cases
    idx_s       = rx_byte[4:0] - 5'd1;
    is_letter_s = ((rx_byte >= 8'd65) && (rx_byte <= 8'd90)) ||
                  ((rx_byte >= 8'd97) && (rx_byte <= 8'd122));
    is_cmd_s    = (rx_byte == 8'd35);
    is_clr_s    = (rx_byte == 8'd33);
  end

  // Command FSM next-state and output logic.
  always_comb begin
    cmd_d           = cmd_q;
    cnt_d           = cnt_q;
    left_d          = left_q;
    mid_d           = mid_q;
    cfg_pos_d       = cfg_pos_q;
    load_pend_d     = 1'b0;
    cfg_load_d      = load_pend_q;
    core_valid_in_d = 1'b0;
    core_char_in_d  = core_char_in_q;
    flush_s         = 1'b0;
    push_s          = 1'b0;
    err_set_s       = 1'b0;
    if (rx_done && is_clr_s) begin
      // Clear wins over everything else, including a same-cycle core result
      cmd_d   = IDLE;
      cnt_d   = {TW{1'b0}};
      flush_s = 1'b1;
    end else begin
      case (cmd_q)
        IDLE: begin
          if (rx_done && is_letter_s && !fifo_full_s) begin
            core_char_in_d  = idx_s;
            core_valid_in_d = 1'b1;
            cnt_d           = {TW{1'b0}};
            cmd_d           = WAIT_CORE;
          end else if (rx_done && is_cmd_s) begin
            cmd_d = CFG1;
          end else begin
            cmd_d = IDLE;
          end
        end
        CFG1: begin
          if (rx_done && is_letter_s) begin
            left_d = idx_s;
            cmd_d  = CFG2;
          end else if (rx_done) begin
            cmd_d = IDLE;
          end else begin
            cmd_d = CFG1;
          end
        end
        CFG2: begin
          if (rx_done && is_letter_s) begin
            mid_d = idx_s;
            cmd_d = CFG3;
          end else if (rx_done) begin
            cmd_d = IDLE;
          end else begin
            cmd_d = CFG2;
          end
        end
        CFG3: begin
          if (rx_done && is_letter_s) begin
            // Positions change now; the load strobe follows once they are stable
            cfg_pos_d   = {left_q, mid_q, idx_s};
            load_pend_d = 1'b1;
            cmd_d       = IDLE;
          end else if (rx_done) begin
            cmd_d = IDLE;
          end else begin
            cmd_d = CFG3;
          end
        end
        WAIT_CORE: begin
          if (core_valid_out) begin
            push_s = 1'b1;
            cmd_d  = IDLE;
          end else if (cnt_q == TW'(TIMEOUT - 1)) begin
            err_set_s = 1'b1;
            cmd_d     = IDLE;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        default: begin
          cmd_d = IDLE;
        end
      endcase
    end
  end

  // TX FSM next-state logic; pops the FIFO head into the transmit register.
  always_comb begin
    tx_d       = tx_q;
    tx_din_d   = tx_din_q;
    tx_start_d = 1'b0;
    seen_d     = seen_q;
    pop_s      = 1'b0;
    case (tx_q)
      TX_IDLE: begin
        if (!fifo_empty_s && !tx_active && !flush_s) begin
          pop_s    = 1'b1;
          tx_din_d = fifo_mem_q[rd_ptr_q];
          tx_d     = TX_START;
        end else begin
          tx_d = TX_IDLE;
        end
      end
      TX_START: begin
        tx_start_d = 1'b1;
        seen_d     = 1'b0;
        tx_d       = TX_WAIT;
      end
      TX_WAIT: begin
        // The UART may raise tx_active a cycle late, so require a high phase first
        if (tx_active) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          tx_d = TX_IDLE;
        end else begin
          tx_d = TX_WAIT;
        end
      end
      default: begin
        tx_d = TX_IDLE;
      end
    endcase
  end

  // FIFO pointer/occupancy update and sticky error flag.
  always_comb begin
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    do_push_s = push_s && (!fifo_full_s || pop_s);
    ovf_s     = push_s && fifo_full_s && !pop_s;
    if (flush_s) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      wr_ptr_d = do_push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      case ({do_push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    if (flush_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q || err_set_s || ovf_s;
    end
    busy_d = (cmd_d != IDLE) || (count_d != {CW{1'b0}});
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q           <= IDLE;
      cnt_q           <= {TW{1'b0}};
      left_q          <= 5'd0;
      mid_q           <= 5'd0;
      cfg_pos_q       <= 15'd0;
      load_pend_q     <= 1'b0;
      cfg_load_q      <= 1'b0;
      core_valid_in_q <= 1'b0;
      core_char_in_q  <= 5'd0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
      wr_ptr_q        <= {PW{1'b0}};
      rd_ptr_q        <= {PW{1'b0}};
      count_q         <= {CW{1'b0}};
      tx_q            <= TX_IDLE;
      tx_din_q        <= 8'd0;
      tx_start_q      <= 1'b0;
      seen_q          <= 1'b0;
    end else begin
      cmd_q           <= cmd_d;
      cnt_q           <= cnt_d;
      left_q          <= left_d;
      mid_q           <= mid_d;
      cfg_pos_q       <= cfg_pos_d;
      load_pend_q     <= load_pend_d;
      cfg_load_q      <= cfg_load_d;
      core_valid_in_q <= core_valid_in_d;
      core_char_in_q  <= core_char_in_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      tx_q            <= tx_d;
      tx_din_q        <= tx_din_d;
      tx_start_q      <= tx_start_d;
      seen_q          <= seen_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 8'd0;
      end
    end else if (do_push_s) begin
      fifo_mem_q[wr_ptr_q] <= push_data_s;
    end else begin
      fifo_mem_q[wr_ptr_q] <= fifo_mem_q[wr_ptr_q];
    end
  end

  assign core_valid_in = core_valid_in_q;
  assign core_char_in  = core_char_in_q;
  assign cfg_load      = cfg_load_q;
  assign cfg_pos       = cfg_pos_q;
  assign tx_start      = tx_start_q;
  assign tx_din        = tx_din_q;
  assign err           = err_q;
  assign busy          = busy_q;

endmodule
